// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants for the write port.
package regfile_pkg;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int ZERO_REG   = 31;
    localparam int FIFO_DEPTH = 2;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/reg_write_port_if.sv
// reg_write_port_if: request and register-array signals of the write port.
interface reg_write_port_if #(parameter int WIDTH = 64);
    import regfile_pkg::*;
    logic                in_valid;
    logic                in_ready;
    addr_t               in_addr;
    logic [WIDTH-1:0]    in_data;
    logic                stall;
    logic [NUM_REGS-1:0] we_onehot;
    logic [WIDTH-1:0]    we_data;
    logic [NUM_REGS-1:0] pending;
    modport master(output in_valid, in_addr, in_data, stall, input in_ready, we_onehot, we_data, pending);
    modport slave(input in_valid, in_addr, in_data, stall, output in_ready, we_onehot, we_data, pending);
endinterface

// File: rtl/reg_write_port_decoder.sv
// decoder_5to32: one-hot register select, all zeros when disabled.
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [ADDR_W-1:0]   sel,
    input  logic                en,
    output logic [NUM_REGS-1:0] out
);
    assign out = en ? (NUM_REGS'(1) << sel) : '0;
endmodule

// File: rtl/reg_write_port.sv
// reg_write_port: 2-entry in-order write queue in front of the register array,
// with a per-register pending mask; register 31 writes retire silently.
module reg_write_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                stall,
    output logic [NUM_REGS-1:0] we_onehot,
    output logic [WIDTH-1:0]    we_data,
    output logic [NUM_REGS-1:0] pending
);
    addr_t               r_addr [FIFO_DEPTH];
    logic [WIDTH-1:0]    r_data [FIFO_DEPTH];
    logic                r_head;
    logic                r_tail;
    logic [1:0]          r_count;
    logic                w_push;
    logic                w_pop;
    logic [FIFO_DEPTH-1:0] w_valid;
    logic [NUM_REGS-1:0] w_dec [FIFO_DEPTH];

    assign in_ready = r_count < 2'(FIFO_DEPTH);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_count != 2'd0) && !stall;
    assign we_data  = (r_count != 2'd0) ? r_data[r_head] : '0;

    decoder_5to32 u_we_dec (
        .sel (r_addr[r_head]),
        .en  (w_pop && r_addr[r_head] != addr_t'(ZERO_REG)),
        .out (we_onehot)
    );

    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_pend
        assign w_valid[g] = (r_count == 2'd2) || (r_count != 2'd0 && r_head == 1'(g));
        decoder_5to32 u_pend_dec (
            .sel (r_addr[g]),
            .en  (w_valid[g] && r_addr[g] != addr_t'(ZERO_REG)),
            .out (w_dec[g])
        );
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) pending = pending | w_dec[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_addr[r_tail] <= in_addr;
                r_data[r_tail] <= in_data;
            end
            r_tail  <= r_tail ^ w_push;
            r_head  <= r_head ^ w_pop;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_reg_write_port.sv
// tb_reg_write_port: directed scenarios plus random traffic against a queue model.
module tb_reg_write_port;
    localparam int W = 64;
    typedef struct { logic [4:0] a; logic [W-1:0] d; } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    logic        exp_ready;
    logic [31:0] exp_we;
    logic [W-1:0] exp_data;
    logic [31:0] exp_pend;

    reg_write_port_if #(.WIDTH(W)) bus ();

    reg_write_port #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_addr   (bus.in_addr),
        .in_data   (bus.in_data),
        .stall     (bus.stall),
        .we_onehot (bus.we_onehot),
        .we_data   (bus.we_data),
        .pending   (bus.pending)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic v, input logic [4:0] a, input logic [W-1:0] d, input logic s);
        reset = r;
        bus.in_valid = v;
        bus.in_addr = a;
        bus.in_data = d;
        bus.stall = s;
        @(negedge clk);
        exp_ready = q.size() < 2;
        exp_we = (q.size() > 0 && !s && q[0].a != 5'd31) ? (32'd1 << q[0].a) : 32'd0;
        exp_data = q.size() > 0 ? q[0].d : '0;
        exp_pend = 32'd0;
        foreach (q[i]) if (q[i].a != 5'd31) exp_pend[q[i].a] = 1'b1;
    endtask

    task automatic advance();
        bit room;
        @(posedge clk);
        room = q.size() < 2;
        if (reset) q.delete();
        else begin
            if (q.size() > 0 && !bus.stall) void'(q.pop_front());
            if (bus.in_valid && room) q.push_back('{a: bus.in_addr, d: bus.in_data});
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 5'd4, 64'h1234, 0);
        advance();
        drive(1, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.we_onehot !== 32'd0 || bus.we_data !== '0 || bus.pending !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b we=%h data=%h pend=%h, want 1/0/0/0", bus.in_ready, bus.we_onehot, bus.we_data, bus.pending);
        end
        advance();
    endtask

    task automatic test_single();
        drive(0, 1, 5'd5, 64'hA5, 0);
        checks++;
        if (bus.we_onehot !== 32'd0) begin errors++; $display("FAIL single_pre: we=%h want 0", bus.we_onehot); end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.we_onehot !== 32'h20 || bus.we_data !== 64'hA5) begin
            errors++;
            $display("FAIL single_write: we=%h data=%h want 00000020/a5", bus.we_onehot, bus.we_data);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.we_onehot !== 32'd0 || bus.we_data !== '0) begin
            errors++;
            $display("FAIL single_once: we=%h data=%h want 0/0", bus.we_onehot, bus.we_data);
        end
        advance();
    endtask

    task automatic test_xzr();
        for (int c = 0; c < 3; c++) begin
            drive(0, c == 0, 5'd31, 64'hFF, 0);
            checks++;
            if (bus.we_onehot !== 32'd0 || bus.in_ready !== 1'b1 || bus.pending !== 32'd0) begin
                errors++;
                $display("FAIL xzr cyc%0d: we=%h ready=%b pend=%h want 0/1/0", c, bus.we_onehot, bus.in_ready, bus.pending);
            end
            advance();
        end
    endtask

    task automatic test_stall();
        logic [31:0] want [3] = '{32'h08, 32'h80, 32'h00};
        drive(0, 1, 5'd3, 64'h3, 1);
        advance();
        drive(0, 1, 5'd7, 64'h7, 1);
        advance();
        drive(0, 1, 5'd9, 64'h9, 1);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.pending !== 32'h88 || bus.we_onehot !== 32'd0) begin
            errors++;
            $display("FAIL stall_full: ready=%b pend=%h we=%h want 0/00000088/0", bus.in_ready, bus.pending, bus.we_onehot);
        end
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (bus.we_onehot !== want[c] || (c == 2 && bus.pending !== 32'd0)) begin
                errors++;
                $display("FAIL stall_drain cyc%0d: we=%h pend=%h want we=%h", c, bus.we_onehot, bus.pending, want[c]);
            end
            advance();
        end
    endtask

    task automatic test_same_reg();
        drive(0, 1, 5'd9, 64'h111, 1);
        advance();
        drive(0, 1, 5'd9, 64'h222, 1);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (c < 2 && (bus.pending !== 32'h200 || bus.we_onehot !== 32'h200 || bus.we_data !== (c == 0 ? 64'h111 : 64'h222))) begin
                errors++;
                $display("FAIL same_reg cyc%0d: pend=%h we=%h data=%h", c, bus.pending, bus.we_onehot, bus.we_data);
            end
            if (c == 2 && bus.pending !== 32'd0) begin
                errors++;
                $display("FAIL same_reg_clear: pend=%h want 0", bus.pending);
            end
            advance();
        end
    endtask

    task automatic test_push_pop();
        drive(0, 1, 5'd4, 64'h44, 0);
        advance();
        drive(0, 1, 5'd2, 64'h22, 0);
        checks++;
        if (bus.we_onehot !== 32'h10 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_first: we=%h ready=%b want 00000010/1", bus.we_onehot, bus.in_ready);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (bus.we_onehot !== 32'h04 || bus.we_data !== 64'h22 || bus.pending !== 32'h04 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_next: we=%h data=%h pend=%h ready=%b want 04/22/04/1", bus.we_onehot, bus.we_data, bus.pending, bus.in_ready);
        end
        advance();
    endtask

    task automatic test_reset_flush();
        drive(0, 1, 5'd12, 64'hC, 1);
        advance();
        drive(0, 1, 5'd13, 64'hD, 1);
        advance();
        drive(1, 1, 5'd6, 64'h6, 0);
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.pending !== 32'd0 || bus.we_onehot !== 32'd0 || bus.we_data !== '0) begin
                errors++;
                $display("FAIL reset_flush cyc%0d: ready=%b pend=%h we=%h data=%h", c, bus.in_ready, bus.pending, bus.we_onehot, bus.we_data);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [4:0] a = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            drive(0, 1'($urandom_range(0, 1)), a, {32'($urandom), 32'($urandom)}, $urandom_range(0, 9) < 3);
            checks++;
            if (bus.in_ready !== exp_ready || bus.we_onehot !== exp_we || bus.we_data !== exp_data || bus.pending !== exp_pend) begin
                errors++;
                $display("FAIL random cyc%0d: ready=%b we=%h data=%h pend=%h want %b/%h/%h/%h", c, bus.in_ready, bus.we_onehot, bus.we_data, bus.pending, exp_ready, exp_we, exp_data, exp_pend);
            end
            advance();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.stall = 1'b0;
        test_reset();
        test_single();
        test_xzr();
        test_stall();
        test_same_reg();
        test_push_pop();
        test_reset_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_write_port.md
REG_WRITE_PORT -- requirements
Module: reg_write_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, meaning register data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a write request is presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have port in_addr, input, 5, meaning destination register number 0..31.
REQ-007 The block SHALL have port in_data, input, WIDTH, meaning the write data.
REQ-008 The block SHALL have port stall, input, 1, meaning the register array cannot take a write this cycle.
REQ-009 The block SHALL have port we_onehot, output, 32, meaning the one-hot per-register write enable.
REQ-010 The block SHALL have port we_data, output, WIDTH, meaning data for the enabled register.
REQ-011 The block SHALL have port pending, output, 32, meaning bit i is set while a queued write targets register i.

Function
REQ-012 The block SHALL hold accepted requests in a 2-entry in-order FIFO (head, tail, count 0..2).
REQ-013 The block SHALL drive in_ready = (count < 2), a function of state only, with no combinational path from stall or in_valid.
REQ-014 The block SHALL push on a clk edge when in_valid && in_ready, storing in_addr and in_data at the tail.
REQ-015 The block SHALL pop the head on a clk edge when count > 0 && !stall.
REQ-016 The block SHALL drive we_onehot as the decoded head address when count > 0 && !stall && head addr != 31, else all zeros; at most one bit is ever set.
REQ-017 Register 31 (XZR) writes SHALL be accepted and SHALL occupy a slot, and SHALL pop normally with we_onehot = 0 (the write is discarded).
REQ-018 The block SHALL drive we_data as the head data when count > 0, else 0.
REQ-019 Latency SHALL be: a request accepted at edge N appears on we_onehot in the cycle after edge N if the FIFO was empty and stall = 0.
REQ-020 With count == 1 and simultaneous push and pop, the block SHALL leave count at 1 with the new entry becoming head.
REQ-021 With count == 2, in_valid SHALL be ignored and requests SHALL be neither accepted nor lost; the requester holds them.
REQ-022 The block SHALL set pending[i] = 1 iff some valid FIFO entry has addr i and i != 31; pending[31] is always 0.
REQ-023 Two queued writes to the same register SHALL retire in order, and pending[i] SHALL stay set until the second one pops.
REQ-024 stall held high SHALL freeze the FIFO contents, keep we_onehot = 0, and keep pending unchanged except for new pushes.
REQ-025 Head and tail pointers SHALL wrap modulo 2.

Reset
REQ-026 While reset = 1 at an edge, the block SHALL set count = 0 and both pointers = 0, discarding all queued writes including a mid-drain write.
REQ-027 In the cycle after reset, the block SHALL drive in_ready = 1, we_onehot = 0, we_data = 0 and pending = 0.
REQ-028 A request presented in the same cycle as reset SHALL NOT be stored.

Structure
REQ-029 Package regfile_pkg SHALL hold NUM_REGS = 32, ADDR_W = 5, ZERO_REG = 31 and FIFO_DEPTH = 2, and reg_write_port SHALL use them.
REQ-030 The block SHALL instantiate one combinational sub-module, decoder_5to32, with ports sel (5), en (1) and out (32), giving a one-hot output when en = 1 and zeros otherwise.
REQ-031 The pending mask SHALL be the OR of per-entry decoder outputs, gated by entry valid.

Verification
REQ-032 Bench: push addr 5, data 0xA5, with stall = 0 -> next cycle we_onehot = 0x00000020 and we_data = 0xA5 for exactly one cycle.
REQ-033 Bench: push addr 31, data 0xFF -> we_onehot stays 0, in_ready stays 1 and pending stays 0 throughout.
REQ-034 Bench: stall = 1, then push addr 3 and addr 7 -> in_ready = 0, pending = 0x00000088; release stall -> we_onehot = 0x08, then 0x80, then pending = 0.
REQ-035 Bench: push addr 9 twice while stalled, then release -> pending[9] stays 1 until the second write retires, and data order is preserved.
REQ-036 Bench: with count == 1, apply simultaneous push (addr 2) and pop -> count stays 1 and we_onehot = 0x04 on the following cycle.
REQ-037 Bench: assert reset with 2 entries queued -> next cycle in_ready = 1, pending = 0, we_onehot = 0, and no queued write ever appears.
